// File: rtl/mp_regfile_sync_if.sv
// Bus bundle for mp_regfile_sync: dual write ports, NUM_RD read ports, clear and error control.
interface mp_regfile_sync_if #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned NUM_RD = 2
);
    logic                     wr_en_a;
    logic                     wr_en_b;
    logic [ADDR_W-1:0]        wr_addr_a;
    logic [ADDR_W-1:0]        wr_addr_b;
    logic [DATA_W-1:0]        wr_data_a;
    logic [DATA_W-1:0]        wr_data_b;
    logic [NUM_RD-1:0]        rd_en;
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_valid;
    logic                     clr_req;
    logic                     ready;
    logic                     wr_collision;
    logic                     addr_err;
    logic                     err_clr;

    // Requester side: drives accesses, observes results.
    modport master (
        output wr_en_a, wr_en_b, wr_addr_a, wr_addr_b, wr_data_a, wr_data_b,
        output rd_en, rd_addr, clr_req, err_clr,
        input  rd_data, rd_valid, ready, wr_collision, addr_err
    );

    // Register-file side.
    modport slave (
        input  wr_en_a, wr_en_b, wr_addr_a, wr_addr_b, wr_data_a, wr_data_b,
        input  rd_en, rd_addr, clr_req, err_clr,
        output rd_data, rd_valid, ready, wr_collision, addr_err
    );
endinterface

// File: rtl/mp_regfile_sync.sv
// Multi-port register file: two write ports, NUM_RD registered read ports with write-first
// bypass, post-reset / on-request zero sweep, collision pulse and sticky range-error flag.
module mp_regfile_sync #(
    parameter int unsigned DEPTH  = 1024,
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned NUM_RD = 2
) (
    input logic              clk,
    input logic              rst,
    mp_regfile_sync_if.slave bus
);
    localparam int unsigned      IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]  DEPTH_W  = (ADDR_W + 1)'(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    typedef enum logic [0:0] {StClear, StIdle} state_e;

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              idle;
    logic              in_a, in_b, we_a, we_b, same_wr, err_set;
    logic [IDX_W-1:0]  idx_a, idx_b;
    logic [NUM_RD-1:0] rd_oor;
    logic              coll_q, err_q;

    // Zero-extend by one bit so DEPTH == 2**ADDR_W still compares correctly.
    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return {1'b0, a} < DEPTH_W;
    endfunction

    assign idle    = (state_q == StIdle);
    assign in_a    = in_range(bus.wr_addr_a);
    assign in_b    = in_range(bus.wr_addr_b);
    assign we_a    = idle & bus.wr_en_a & in_a;
    assign we_b    = idle & bus.wr_en_b & in_b;
    assign same_wr = we_a & we_b & (bus.wr_addr_a == bus.wr_addr_b);
    assign idx_a   = bus.wr_addr_a[IDX_W-1:0];
    assign idx_b   = bus.wr_addr_b[IDX_W-1:0];
    assign err_set = idle & ((bus.wr_en_a & ~in_a) | (bus.wr_en_b & ~in_b) | (|rd_oor));

    // State and sweep pointer; reset restarts the sweep from entry 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StClear;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // Next state: sweep one entry per edge, clr_req only honoured from idle.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            StClear: begin
                if (ptr_q == LAST_IDX) begin
                    state_d = StIdle;
                    ptr_d   = '0;
                end else begin
                    ptr_d = ptr_q + 1'b1;
                end
            end
            StIdle: begin
                if (bus.clr_req) begin
                    state_d = StClear;
                    ptr_d   = '0;
                end
            end
            default: state_d = StClear;
        endcase
    end

    // Array write: sweep zeroes, else port B overrides port A on the same entry.
    always_ff @(posedge clk) begin
        if (state_q == StClear) begin
            mem[ptr_q] <= '0;
        end else begin
            if (we_a && !same_wr) mem[idx_a] <= bus.wr_data_a;
            if (we_b)             mem[idx_b] <= bus.wr_data_b;
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic              ra_ok;
        logic [DATA_W-1:0] data_d, data_q;
        logic              valid_d, valid_q;

        assign ra        = bus.rd_addr[i*ADDR_W +: ADDR_W];
        assign ra_ok     = in_range(ra);
        assign rd_oor[i] = bus.rd_en[i] & ~ra_ok;

        // Read mux: write-first bypass (B before A), zero when out of range or not ready.
        always_comb begin
            data_d  = data_q;
            valid_d = 1'b0;
            if (bus.rd_en[i]) begin
                if (!idle) begin
                    data_d = '0;
                end else begin
                    valid_d = 1'b1;
                    if (!ra_ok)                             data_d = '0;
                    else if (we_b && ra == bus.wr_addr_b) data_d = bus.wr_data_b;
                    else if (we_a && ra == bus.wr_addr_a) data_d = bus.wr_data_a;
                    else                                    data_d = mem[ra[IDX_W-1:0]];
                end
            end
        end

        // Registered read data and valid pulse.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                data_q  <= '0;
                valid_q <= 1'b0;
            end else begin
                data_q  <= data_d;
                valid_q <= valid_d;
            end
        end

        assign bus.rd_data[i*DATA_W +: DATA_W] = data_q;
        assign bus.rd_valid[i]                 = valid_q;
    end

    // Collision pulse and sticky error; a new error wins over err_clr.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            coll_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            coll_q <= same_wr;
            err_q  <= err_set | (err_q & ~bus.err_clr);
        end
    end

    assign bus.ready        = idle;
    assign bus.wr_collision = coll_q;
    assign bus.addr_err     = err_q;
endmodule

// File: tb/tb_mp_regfile_sync.sv
// Directed bench: DEPTH=16 instance for the main behaviour, DEPTH=12 instance for range errors.
module tb_mp_regfile_sync;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    mp_regfile_sync_if #(.ADDR_W(5), .DATA_W(8), .NUM_RD(2)) bus16 ();
    mp_regfile_sync_if #(.ADDR_W(4), .DATA_W(8), .NUM_RD(2)) bus12 ();

    mp_regfile_sync #(.DEPTH(16), .ADDR_W(5), .DATA_W(8), .NUM_RD(2)) u_dut16 (
        .clk (clk),
        .rst (rst),
        .bus (bus16.slave)
    );

    mp_regfile_sync #(.DEPTH(12), .ADDR_W(4), .DATA_W(8), .NUM_RD(2)) u_dut12 (
        .clk (clk),
        .rst (rst),
        .bus (bus12.slave)
    );

    typedef struct {
        logic       wea;
        logic [4:0] aa;
        logic [7:0] da;
        logic       web;
        logic [4:0] ab;
        logic [7:0] db;
        logic [1:0] re;
        logic [4:0] r0;
        logic [4:0] r1;
        logic       ec;
        logic [1:0] ev;
        logic [7:0] e0;
        logic [7:0] e1;
        logic       ecol;
        logic       eerr;
    } vec_t;

    vec_t vecs [15];

    function automatic vec_t mk(input logic wea, input logic [4:0] aa, input logic [7:0] da,
                                input logic web, input logic [4:0] ab, input logic [7:0] db,
                                input logic [1:0] re, input logic [4:0] r0, input logic [4:0] r1,
                                input logic ec, input logic [1:0] ev, input logic [7:0] e0,
                                input logic [7:0] e1, input logic ecol, input logic eerr);
        vec_t v;
        v.wea = wea; v.aa = aa; v.da = da; v.web = web; v.ab = ab; v.db = db;
        v.re = re; v.r0 = r0; v.r1 = r1; v.ec = ec; v.ev = ev; v.e0 = e0; v.e1 = e1;
        v.ecol = ecol; v.eerr = eerr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle16();
        bus16.wr_en_a = 0; bus16.wr_addr_a = '0; bus16.wr_data_a = '0;
        bus16.wr_en_b = 0; bus16.wr_addr_b = '0; bus16.wr_data_b = '0;
        bus16.rd_en = '0; bus16.rd_addr = '0; bus16.clr_req = 0; bus16.err_clr = 0;
    endtask

    task automatic idle12();
        bus12.wr_en_a = 0; bus12.wr_addr_a = '0; bus12.wr_data_a = '0;
        bus12.wr_en_b = 0; bus12.wr_addr_b = '0; bus12.wr_data_b = '0;
        bus12.rd_en = '0; bus12.rd_addr = '0; bus12.clr_req = 0; bus12.err_clr = 0;
    endtask

    task automatic read_all_zero16(input string tag);
        for (int a = 0; a < 16; a += 2) begin
            bus16.rd_en   = 2'b11;
            bus16.rd_addr = {5'(a + 1), 5'(a)};
            step();
            chk($sformatf("%s rd_data @%0d", tag, a), bus16.rd_data, 16'h0000);
            chk($sformatf("%s rd_valid @%0d", tag, a), bus16.rd_valid, 2'b11);
        end
        idle16();
        step();
        chk({tag, " rd_valid drop"}, bus16.rd_valid, 2'b00);
    endtask

    initial begin
        vecs[0]  = mk(1, 3, 8'h5A, 0, 0, 8'h00, 2'b01, 3, 0, 0, 2'b01, 8'h5A, 8'h00, 0, 0);
        vecs[1]  = mk(1, 7, 8'h11, 1, 7, 8'h22, 2'b00, 0, 0, 0, 2'b00, 8'h5A, 8'h00, 1, 0);
        vecs[2]  = mk(0, 0, 8'h00, 0, 0, 8'h00, 2'b11, 7, 3, 0, 2'b11, 8'h22, 8'h5A, 0, 0);
        vecs[3]  = mk(1, 9, 8'hA1, 1, 10, 8'hB2, 2'b11, 9, 10, 0, 2'b11, 8'hA1, 8'hB2, 0, 0);
        vecs[4]  = mk(0, 0, 8'h00, 0, 0, 8'h00, 2'b11, 10, 10, 0, 2'b11, 8'hB2, 8'hB2, 0, 0);
        vecs[5]  = mk(1, 12, 8'h33, 1, 12, 8'h44, 2'b01, 12, 0, 0, 2'b01, 8'h44, 8'hB2, 1, 0);
        vecs[6]  = mk(0, 0, 8'h00, 0, 0, 8'h00, 2'b10, 0, 12, 0, 2'b10, 8'h44, 8'h44, 0, 0);
        vecs[7]  = mk(1, 20, 8'hFF, 0, 0, 8'h00, 2'b01, 4, 0, 0, 2'b01, 8'h00, 8'h44, 0, 1);
        vecs[8]  = mk(0, 0, 8'h00, 0, 0, 8'h00, 2'b11, 4, 31, 0, 2'b11, 8'h00, 8'h00, 0, 1);
        vecs[9]  = mk(0, 0, 8'h00, 0, 0, 8'h00, 2'b00, 0, 0, 1, 2'b00, 8'h00, 8'h00, 0, 0);
        vecs[10] = mk(0, 0, 8'h00, 0, 0, 8'h00, 2'b01, 16, 0, 1, 2'b01, 8'h00, 8'h00, 0, 1);
        vecs[11] = mk(0, 0, 8'h00, 0, 0, 8'h00, 2'b00, 0, 0, 1, 2'b00, 8'h00, 8'h00, 0, 0);
        vecs[12] = mk(1, 5, 8'h66, 1, 6, 8'h77, 2'b11, 5, 6, 0, 2'b11, 8'h66, 8'h77, 0, 0);
        vecs[13] = mk(1, 0, 8'h01, 1, 18, 8'h99, 2'b11, 0, 2, 0, 2'b11, 8'h01, 8'h00, 0, 1);
        vecs[14] = mk(0, 0, 8'h00, 0, 0, 8'h00, 2'b01, 3, 0, 1, 2'b01, 8'h5A, 8'h00, 0, 0);

        idle16();
        idle12();
        repeat (3) step();
        chk("reset ready", bus16.ready, 1'b0);
        chk("reset rd_valid", bus16.rd_valid, 2'b00);
        chk("reset rd_data", bus16.rd_data, 16'h0000);
        chk("reset wr_collision", bus16.wr_collision, 1'b0);
        chk("reset addr_err", bus16.addr_err, 1'b0);

        // Release away from the edge; ready must rise after exactly DEPTH edges.
        rst = 1'b1;
        for (int e = 1; e <= 16; e++) begin
            step();
            chk($sformatf("sweep16 ready edge %0d", e), bus16.ready, 1'(e == 16));
            if (e == 11 || e == 12)
                chk($sformatf("sweep12 ready edge %0d", e), bus12.ready, 1'(e == 12));
        end
        read_all_zero16("init");

        for (int i = 0; i < 15; i++) begin
            bus16.wr_en_a = vecs[i].wea; bus16.wr_addr_a = vecs[i].aa;
            bus16.wr_data_a = vecs[i].da;
            bus16.wr_en_b = vecs[i].web; bus16.wr_addr_b = vecs[i].ab;
            bus16.wr_data_b = vecs[i].db;
            bus16.rd_en = vecs[i].re; bus16.rd_addr = {vecs[i].r1, vecs[i].r0};
            bus16.err_clr = vecs[i].ec;
            step();
            chk($sformatf("vec%0d rd_valid", i), bus16.rd_valid, vecs[i].ev);
            chk($sformatf("vec%0d rd_data", i), bus16.rd_data, {vecs[i].e1, vecs[i].e0});
            chk($sformatf("vec%0d wr_collision", i), bus16.wr_collision, vecs[i].ecol);
            chk($sformatf("vec%0d addr_err", i), bus16.addr_err, vecs[i].eerr);
        end
        idle16();

        // Requested sweep: accesses and repeated clr_req ignored while not ready.
        bus16.clr_req = 1'b1;
        step();
        chk("clr ready drop", bus16.ready, 1'b0);
        for (int e = 1; e <= 16; e++) begin
            bus16.wr_en_a = 1'b1; bus16.wr_addr_a = 5'd1; bus16.wr_data_a = 8'hAA;
            bus16.rd_en = 2'b11; bus16.rd_addr = {5'd3, 5'd5};
            step();
            chk($sformatf("clr ready edge %0d", e), bus16.ready, 1'(e == 16));
            chk($sformatf("clr rd_valid edge %0d", e), bus16.rd_valid, 2'b00);
            chk($sformatf("clr rd_data edge %0d", e), bus16.rd_data, 16'h0000);
        end
        idle16();
        read_all_zero16("post_clr");

        // Out-of-range handling on the non-power-of-two instance.
        bus12.wr_en_a = 1'b1; bus12.wr_addr_a = 4'd14; bus12.wr_data_a = 8'hFF;
        step();
        chk("d12 wr oor addr_err", bus12.addr_err, 1'b1);
        idle12();
        bus12.rd_en = 2'b01; bus12.rd_addr = {4'd0, 4'd14};
        step();
        chk("d12 rd oor rd_valid", bus12.rd_valid, 2'b01);
        chk("d12 rd oor rd_data", bus12.rd_data[7:0], 8'h00);
        chk("d12 rd oor addr_err", bus12.addr_err, 1'b1);
        bus12.err_clr = 1'b1; bus12.rd_addr = {4'd0, 4'd2};
        step();
        chk("d12 err_clr", bus12.addr_err, 1'b0);
        chk("d12 alias rd_data", bus12.rd_data[7:0], 8'h00);
        chk("d12 alias rd_valid", bus12.rd_valid, 2'b01);
        idle12();

        // Reset in the middle of a sweep.
        bus16.wr_en_a = 1'b1; bus16.wr_addr_a = 5'd3; bus16.wr_data_a = 8'h5A;
        step();
        idle16();
        bus16.rd_en = 2'b11; bus16.rd_addr = {5'd25, 5'd3};
        step();
        chk("pre-rst rd_data", bus16.rd_data, 16'h005A);
        chk("pre-rst addr_err", bus16.addr_err, 1'b1);
        idle16();
        bus16.clr_req = 1'b1;
        step();
        bus16.clr_req = 1'b0;
        repeat (8) step();
        #2 rst = 1'b0;
        #1;
        chk("mid rst ready", bus16.ready, 1'b0);
        chk("mid rst rd_data", bus16.rd_data, 16'h0000);
        chk("mid rst rd_valid", bus16.rd_valid, 2'b00);
        chk("mid rst addr_err", bus16.addr_err, 1'b0);
        step();
        rst = 1'b1;
        for (int e = 1; e <= 16; e++) begin
            step();
            chk($sformatf("resweep ready edge %0d", e), bus16.ready, 1'(e == 16));
        end
        read_all_zero16("resweep");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mp_regfile_sync.md
MP_REGFILE_SYNC -- requirements
Module: mp_regfile_sync

Interface
REQ-001 SHALL have parameter DEPTH, default 1024, number of entries (2..2^ADDR_W).
REQ-002 SHALL have parameter ADDR_W, default 10, address width.
REQ-003 SHALL have parameter DATA_W, default 8, entry width.
REQ-004 SHALL have parameter NUM_RD, default 2, number of independent read ports (1..8).
REQ-005 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-006 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-007 SHALL have ports wr_en_a, wr_en_b  input  1 each  write strobes for ports A and B.
REQ-008 SHALL have ports wr_addr_a, wr_addr_b  input  ADDR_W each  write addresses.
REQ-009 SHALL have ports wr_data_a, wr_data_b  input  DATA_W each  write data.
REQ-010 SHALL have port rd_en  input  NUM_RD  per-port read strobe.
REQ-011 SHALL have port rd_addr  input  NUM_RD*ADDR_W  packed read addresses, port i at [i*ADDR_W +: ADDR_W].
REQ-012 SHALL have port rd_data  output  NUM_RD*DATA_W  packed registered read data.
REQ-013 SHALL have port rd_valid  output  NUM_RD  one-cycle pulse per completed read.
REQ-014 SHALL have port clr_req  input  1  request full-array zero sweep.
REQ-015 SHALL have port ready  output  1  high when array accepts reads/writes.
REQ-016 SHALL have port wr_collision  output  1  one-cycle pulse on same-address dual write.
REQ-017 SHALL have port addr_err  output  1  sticky out-of-range access flag.
REQ-018 SHALL have port err_clr  input  1  clears addr_err.

Function
REQ-019 SHALL implement FSM states CLEAR and IDLE; ready = (state==IDLE), registered.
REQ-020 CLEAR: each edge SHALL write zero to mem[ptr], ptr+1; edge writing ptr==DEPTH-1 SHALL move to IDLE, ptr to 0.
REQ-021 IDLE: clr_req=1 at an edge SHALL enter CLEAR with ptr=0; clr_req in CLEAR SHALL be ignored.
REQ-022 While ready=0, wr_en_a/b SHALL be ignored and rd_en SHALL yield rd_valid=0, rd_data=0.
REQ-023 Read latency SHALL be one cycle: rd_en[i]=1 at edge N -> rd_data[i] and rd_valid[i]=1 after edge N; rd_en[i]=0 -> rd_valid[i]=0, rd_data[i] holds.
REQ-024 Write-first bypass: read and in-range write to same address at same edge SHALL return the new data; if both ports write it, port B data.
REQ-025 Both ports writing the same in-range address SHALL store wr_data_b and pulse wr_collision for one cycle; different addresses SHALL both be stored.
REQ-026 Address >= DEPTH: write SHALL be dropped; read SHALL return 0 with rd_valid=1; either SHALL set addr_err.
REQ-027 err_clr=1 SHALL clear addr_err at the edge; simultaneous set and err_clr SHALL leave addr_err=1.
REQ-028 Read ports SHALL be fully independent; any number may address the same entry.
REQ-029 Address comparisons SHALL be unsigned at ADDR_W bits; no wrap-around of out-of-range addresses.

Reset
REQ-030 rst=0 SHALL immediately force state=CLEAR, ptr=0, ready=0, rd_data=0, rd_valid=0, wr_collision=0, addr_err=0.
REQ-031 Memory SHALL be zeroed by the post-reset sweep, not the reset itself; ready SHALL rise after the DEPTH-th edge following release.
REQ-032 Reset asserted mid-sweep or mid-operation SHALL restart the sweep from ptr=0.

Verification
REQ-033 DEPTH=16: release rst -> ready=0 for 15 edges, 1 after 16th; read all entries -> 0x00, rd_valid pulses.
REQ-034 Write A addr 3=0x5A, same edge rd_en[0] addr 3 -> next cycle rd_data[0]=0x5A, rd_valid[0]=1.
REQ-035 Write A addr 7=0x11 and B addr 7=0x22 same edge -> wr_collision 1-cycle pulse; later read addr 7 = 0x22.
REQ-036 DEPTH=12, write addr 14=0xFF -> dropped, addr_err=1; read addr 14 -> 0x00, rd_valid=1; err_clr -> addr_err=0.
REQ-037 Fill entries, clr_req -> ready=0 DEPTH cycles, writes ignored; afterward all reads 0x00.
REQ-038 Assert rst at sweep ptr=8 -> outputs zero immediately; release -> full DEPTH-cycle sweep again.
